reg_uart_dump: RTL and testbench

REG_UART_DUMP -- requirements
Module: reg_uart_dump

---
 rtl/reg_uart_dump_if.sv | 24 ++
 rtl/reg_uart_dump.sv | 139 +++++++++++++
 tb/tb_reg_uart_dump.sv | 238 +++++++++++++++++++++++
 3 files changed

// File: rtl/reg_uart_dump_if.sv
// rtl/reg_uart_dump_if.sv - register-dump request/status and UART line bundle
interface reg_uart_dump_if;
    logic [31:0] regData;
    logic        start;
    logic        busy;
    logic        done;
    logic        tx;

    modport master (
        output regData,
        output start,
        input  busy,
        input  done,
        input  tx
    );

    modport slave (
        input  regData,
        input  start,
        output busy,
        output done,
        output tx
    );
endinterface

// File: rtl/reg_uart_dump.sv
// rtl/reg_uart_dump.sv - dumps a 32-bit register as 8 uppercase hex digits (+CRLF) over 8N1 UART
module reg_uart_dump #(
    parameter int CLK_DIV   = 868,
    parameter bit SEND_CRLF = 1'b1
) (
    input  logic           clk,
    input  logic           rst,
    reg_uart_dump_if.slave bus
);

    localparam logic [3:0]  LAST_CHAR = SEND_CRLF ? 4'd9 : 4'd7;
    localparam logic [15:0] TICK_MAX  = 16'(CLK_DIV - 1);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t      state, state_n;
    logic [15:0] timer, timer_n;
    logic [2:0]  bit_idx, bit_n;
    logic [3:0]  char_idx, char_n;
    logic [31:0] shadow, shadow_n;
    logic        tx_q, tx_n;
    logic        busy_q, busy_n;
    logic        done_q, done_n;

    logic        tick;
    logic [2:0]  nib_sel;
    logic [3:0]  nibble;
    logic [7:0]  cur_char;
    logic [2:0]  next_bit;

    assign tick     = (timer == TICK_MAX);
    assign next_bit = bit_idx + 3'd1;

    // Character 0 is the most significant nibble; 8 and 9 are CR and LF.
    always_comb begin
        nib_sel = 3'd7 - char_idx[2:0];
        nibble  = shadow[{nib_sel, 2'b00} +: 4];
        if (char_idx == 4'd8)
            cur_char = 8'h0D;
        else if (char_idx == 4'd9)
            cur_char = 8'h0A;
        else if (nibble < 4'd10)
            cur_char = 8'h30 + {4'd0, nibble};
        else
            cur_char = 8'h37 + {4'd0, nibble};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            timer    <= '0;
            bit_idx  <= '0;
            char_idx <= '0;
            shadow   <= '0;
            tx_q     <= 1'b1;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state    <= state_n;
            timer    <= timer_n;
            bit_idx  <= bit_n;
            char_idx <= char_n;
            shadow   <= shadow_n;
            tx_q     <= tx_n;
            busy_q   <= busy_n;
            done_q   <= done_n;
        end
    end

    // tx is registered, so each branch sets the level for the bit that begins on this edge.
    always_comb begin
        state_n  = state;
        timer_n  = timer;
        bit_n    = bit_idx;
        char_n   = char_idx;
        shadow_n = shadow;
        tx_n     = tx_q;
        busy_n   = busy_q;
        done_n   = 1'b0;

        if (state != IDLE)
            timer_n = tick ? 16'd0 : timer + 16'd1;

        case (state)
            IDLE: begin
                tx_n    = 1'b1;
                busy_n  = 1'b0;
                timer_n = '0;
                if (bus.start) begin
                    shadow_n = bus.regData;
                    char_n   = '0;
                    bit_n    = '0;
                    state_n  = START;
                    tx_n     = 1'b0;
                    busy_n   = 1'b1;
                end
            end
            START: begin
                if (tick) begin
                    state_n = DATA;
                    bit_n   = '0;
                    tx_n    = cur_char[0];
                end
            end
            DATA: begin
                if (tick) begin
                    if (bit_idx == 3'd7) begin
                        state_n = STOP;
                        tx_n    = 1'b1;
                    end else begin
                        bit_n = next_bit;
                        tx_n  = cur_char[next_bit];
                    end
                end
            end
            STOP: begin
                if (tick) begin
                    if (char_idx == LAST_CHAR) begin
                        state_n = IDLE;
                        busy_n  = 1'b0;
                        done_n  = 1'b1;
                        tx_n    = 1'b1;
                        char_n  = '0;
                    end else begin
                        char_n  = char_idx + 4'd1;
                        state_n = START;
                        tx_n    = 1'b0;
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end

    assign bus.tx   = tx_q;
    assign bus.busy = busy_q;
    assign bus.done = done_q;

endmodule

// File: tb/tb_reg_uart_dump.sv
// tb/tb_reg_uart_dump.sv - randomized directed bench for reg_uart_dump against a UART text model
module tb_reg_uart_dump;

    typedef bit         bitq_t[$];
    typedef logic [7:0] byteq_t[$];

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    reg_uart_dump_if if_a ();
    reg_uart_dump_if if_b ();
    reg_uart_dump_if if_c ();

    reg_uart_dump #(.CLK_DIV(4), .SEND_CRLF(1'b1)) u_a (.clk(clk), .rst(rst), .bus(if_a.slave));
    reg_uart_dump #(.CLK_DIV(4), .SEND_CRLF(1'b0)) u_b (.clk(clk), .rst(rst), .bus(if_b.slave));
    reg_uart_dump #(.CLK_DIV(2), .SEND_CRLF(1'b1)) u_c (.clk(clk), .rst(rst), .bus(if_c.slave));

    logic [31:0] data_v [3];
    logic        start_v[3];
    logic        tx_s   [3];
    logic        busy_s [3];
    logic        done_s [3];

    assign if_a.regData = data_v[0];
    assign if_b.regData = data_v[1];
    assign if_c.regData = data_v[2];
    assign if_a.start   = start_v[0];
    assign if_b.start   = start_v[1];
    assign if_c.start   = start_v[2];
    assign tx_s[0] = if_a.tx;   assign busy_s[0] = if_a.busy;   assign done_s[0] = if_a.done;
    assign tx_s[1] = if_b.tx;   assign busy_s[1] = if_b.busy;   assign done_s[1] = if_b.done;
    assign tx_s[2] = if_c.tx;   assign busy_s[2] = if_c.busy;   assign done_s[2] = if_c.done;

    int    n_pass  = 0;
    int    n_total = 0;
    bitq_t cap_w;
    int    cap_busy;
    int    cap_done;

    task automatic chk(input string tag, input longint obs, input longint exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    // Expected text: eight hex digits via a lookup table, then optional CR LF.
    function automatic byteq_t hex_text(input logic [31:0] v, input bit crlf);
        byteq_t q;
        string  digits = "0123456789ABCDEF";
        for (int n = 7; n >= 0; n--)
            q.push_back(digits.getc(int'(v[4*n +: 4])));
        if (crlf) begin
            q.push_back(8'h0D);
            q.push_back(8'h0A);
        end
        return q;
    endfunction

    function automatic bitq_t make_wave(input byteq_t b, input int div);
        bitq_t q;
        foreach (b[c]) begin
            for (int i = 0; i < 10; i++) begin
                bit lvl;
                lvl = (i == 0) ? 1'b0 : (i == 9) ? 1'b1 : b[c][i-1];
                repeat (div) q.push_back(lvl);
            end
        end
        return q;
    endfunction

    // Mid-bit sampling receiver over the captured line samples.
    function automatic byteq_t decode(input bitq_t w, input int div);
        byteq_t q;
        int     i = 0;
        while (i < w.size()) begin
            if (w[i] == 1'b0 && i + 10*div <= w.size()) begin
                logic [7:0] by;
                for (int j = 0; j < 8; j++)
                    by[j] = w[i + div*(1+j) + div/2];
                q.push_back(by);
                i += 10*div;
            end else begin
                i++;
            end
        end
        return q;
    endfunction

    task automatic start_dump(input int k, input logic [31:0] v, input bit hold);
        @(negedge clk);
        data_v[k]  = v;
        start_v[k] = 1'b1;
        @(negedge clk);
        if (!hold) start_v[k] = 1'b0;
        chk("accept_busy", busy_s[k], 1);
        chk("accept_start_bit", tx_s[k], 0);
    endtask

    task automatic capture(input int k, input int mid_cyc, input logic [31:0] mid_val, input bit start_after);
        cap_w.delete();
        cap_busy = 0;
        cap_done = 0;
        while (busy_s[k] === 1'b1 && cap_busy < 20000) begin
            cap_w.push_back(tx_s[k]);
            cap_busy++;
            if (done_s[k] === 1'b1) cap_done++;
            if (cap_busy == mid_cyc) begin
                data_v[k]  = mid_val;
                start_v[k] = start_after;
            end
            @(negedge clk);
        end
        chk("capture_bounded", cap_busy < 20000, 1);
    endtask

    task automatic verify(input string tag, input int k, input int div, input bit crlf, input logic [31:0] v);
        byteq_t exp_b, got_b;
        bitq_t  exp_w;
        int     mism = 0;
        exp_b = hex_text(v, crlf);
        exp_w = make_wave(exp_b, div);
        chk({tag, "_busy_cycles"}, cap_busy, exp_b.size() * 10 * div);
        chk({tag, "_done_while_busy"}, cap_done, 0);
        chk({tag, "_done_at_end"}, done_s[k], 1);
        for (int i = 0; i < exp_w.size(); i++)
            if (i >= cap_w.size() || cap_w[i] != exp_w[i]) mism++;
        chk({tag, "_wave_mismatches"}, mism, 0);
        got_b = decode(cap_w, div);
        chk({tag, "_byte_count"}, got_b.size(), exp_b.size());
        foreach (exp_b[i])
            chk($sformatf("%s_byte%0d", tag, i), (i < got_b.size()) ? got_b[i] : 8'hxx, exp_b[i]);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] v1, v2;
        int          dn;

        rst = 1'b1;
        for (int k = 0; k < 3; k++) begin
            data_v[k]  = '0;
            start_v[k] = 1'b0;
        end
        repeat (3) @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("reset_tx%0d", k), tx_s[k], 1);
            chk($sformatf("reset_busy%0d", k), busy_s[k], 0);
            chk($sformatf("reset_done%0d", k), done_s[k], 0);
        end
        rst = 1'b0;

        start_dump(0, 32'h1234ABCD, 1'b0);
        capture(0, -1, '0, 1'b0);
        verify("a_1234abcd", 0, 4, 1'b1, 32'h1234ABCD);
        @(negedge clk);
        chk("a_done_one_cycle", done_s[0], 0);
        chk("a_idle_tx", tx_s[0], 1);

        start_dump(0, 32'h00000000, 1'b0);
        capture(0, -1, '0, 1'b0);
        verify("a_zeros", 0, 4, 1'b1, 32'h00000000);
        data_v[0]  = 32'hFFFFFFFF;
        start_v[0] = 1'b1;
        @(negedge clk);
        start_v[0] = 1'b0;
        chk("b2b_restart_busy", busy_s[0], 1);
        chk("b2b_restart_tx", tx_s[0], 0);
        capture(0, -1, '0, 1'b0);
        verify("a_ones", 0, 4, 1'b1, 32'hFFFFFFFF);

        v1 = $urandom;
        v2 = $urandom;
        @(negedge clk);
        data_v[0]  = v1;
        start_v[0] = 1'b1;
        @(negedge clk);
        chk("held_first_busy", busy_s[0], 1);
        capture(0, 10, v2, 1'b1);
        verify("held_first_latched", 0, 4, 1'b1, v1);
        @(negedge clk);
        chk("held_rearm_after_one_idle", busy_s[0], 1);
        capture(0, 10, v2, 1'b0);
        verify("held_second", 0, 4, 1'b1, v2);
        @(negedge clk);
        chk("held_no_extra_dump", busy_s[0], 0);
        repeat (5) @(negedge clk);
        chk("held_still_idle", busy_s[0], 0);

        start_dump(0, 32'h13579BDF, 1'b0);
        repeat (90) @(negedge clk);
        chk("rst_pre_busy", busy_s[0], 1);
        #2 rst = 1'b1;
        #1;
        chk("rst_async_tx", tx_s[0], 1);
        chk("rst_async_busy", busy_s[0], 0);
        dn = 0;
        repeat (3) begin
            @(negedge clk);
            dn += int'(done_s[0]);
        end
        rst = 1'b0;
        repeat (4) begin
            @(negedge clk);
            dn += int'(done_s[0]);
        end
        chk("rst_no_done", dn, 0);
        v1 = $urandom;
        start_dump(0, v1, 1'b0);
        capture(0, -1, '0, 1'b0);
        verify("a_after_rst", 0, 4, 1'b1, v1);

        start_dump(1, 32'hDEADBEEF, 1'b0);
        capture(1, -1, '0, 1'b0);
        verify("b_deadbeef", 1, 4, 1'b0, 32'hDEADBEEF);
        v1 = $urandom;
        start_dump(1, v1, 1'b0);
        capture(1, 7, $urandom, 1'b0);
        verify("b_random", 1, 4, 1'b0, v1);

        for (int r = 0; r < 3; r++) begin
            v1 = $urandom;
            repeat ($urandom_range(0, 5)) @(negedge clk);
            start_dump(2, v1, 1'b0);
            capture(2, 5, $urandom, 1'b0);
            verify($sformatf("c_div2_%0d", r), 2, 2, 1'b1, v1);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
